// File: rtl/pe_switch_ctx_seq_if.sv
// Configuration write port of the switch-context sequencer: the loader is the
// master and pushes context words into the sequencer's slave port.
interface pe_switch_ctx_seq_if #(
    parameter int PTR_W = 4,
    parameter int SW_W  = 24
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PTR_W-1:0] cfg_addr;
    logic [SW_W-1:0]  cfg_data;

    modport master (output cfg_valid, cfg_addr, cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, cfg_addr, cfg_data, output cfg_ready);
endinterface

// File: rtl/pe_switch_ctx_seq.sv
// Stores CTX_DEPTH crossbar switch words and, on start, plays them out one per
// non-stalled cycle as a registered switch word for a PE crossbar.
module pe_switch_ctx_seq #(
    parameter int CTX_DEPTH = 16,
    parameter int PTR_W     = 4,
    parameter int SW_W      = 24
) (
    input  logic                clk,
    input  logic                rst,
    pe_switch_ctx_seq_if.slave  cfg,
    input  logic                start,
    input  logic [PTR_W:0]      ctx_len,
    input  logic                loop_en,
    input  logic                stall,
    input  logic                abort,
    output logic [SW_W-1:0]     switch,
    output logic [PTR_W-1:0]    ctx_idx,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [PTR_W:0] DEPTH_W = (PTR_W+1)'(CTX_DEPTH);

    state_t           state;
    logic [PTR_W:0]   len;
    logic             loop_q;
    logic [SW_W-1:0]  mem [CTX_DEPTH];

    logic             wr_en;
    logic             addr_ok;
    logic             last;
    logic [PTR_W-1:0] nxt;

    function automatic logic bad_nibble(input logic [SW_W-1:0] w);
        bad_nibble = 1'b0;
        for (int i = 0; i < SW_W/4; i++)
            if (w[4*i +: 4] > 4'd8) bad_nibble = 1'b1;
    endfunction

    assign cfg.cfg_ready = (state == IDLE) && !start;
    assign wr_en   = cfg.cfg_valid && cfg.cfg_ready;
    assign addr_ok = {1'b0, cfg.cfg_addr} < DEPTH_W;
    assign nxt     = ctx_idx + 1'b1;
    assign last    = ({1'b0, ctx_idx} + 1'b1) == len;

    // Context storage is deliberately left unreset; rst only blocks a write in flight.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && addr_ok)
            mem[cfg.cfg_addr] <= cfg.cfg_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            switch  <= '1;
            ctx_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            len     <= '0;
            loop_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_en && (!addr_ok || bad_nibble(cfg.cfg_data)))
                cfg_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (start && ctx_len != '0) begin
                        len     <= (ctx_len > DEPTH_W) ? DEPTH_W : ctx_len;
                        loop_q  <= loop_en;
                        state   <= RUN;
                        switch  <= mem[0];
                        ctx_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        switch  <= '1;
                        ctx_idx <= '0;
                        busy    <= 1'b0;
                    end else if (!stall) begin
                        if (!last) begin
                            ctx_idx <= nxt;
                            switch  <= mem[nxt];
                        end else if (loop_q) begin
                            ctx_idx <= '0;
                            switch  <= mem[0];
                        end else begin
                            state   <= IDLE;
                            switch  <= '1;
                            ctx_idx <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_switch_ctx_seq.sv
// Scoreboard bench: a queue-based reference model predicts every cycle's outputs,
// a monitor pops and compares on the falling edge.
module tb_pe_switch_ctx_seq;
    localparam int DEPTH = 16;
    localparam int PW    = 4;
    localparam int SW    = 24;

    typedef struct packed {
        logic [SW-1:0] sw;
        logic [PW-1:0] idx;
        logic          busy;
        logic          done;
        logic          err;
    } exp_t;

    typedef struct packed {
        logic [SW-1:0] sw;
        logic          busy;
        logic          done;
        logic          err;
    } exp12_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, loop_en, stall, abort;
    logic [PW:0]   ctx_len;
    logic [SW-1:0] switch;
    logic [PW-1:0] ctx_idx;
    logic          busy, done, cfg_err;

    logic          start12, loop12, stall12, abort12;
    logic [PW:0]   len12;
    logic [SW-1:0] switch12;
    logic [PW-1:0] idx12;
    logic          busy12, done12, err12;

    int vectors = 0;
    int miscompares = 0;

    exp_t   exp_q[$];
    exp12_t q12[$];

    pe_switch_ctx_seq_if #(.PTR_W(PW), .SW_W(SW)) cfg_if ();
    pe_switch_ctx_seq_if #(.PTR_W(PW), .SW_W(SW)) cfg12_if ();

    pe_switch_ctx_seq #(.CTX_DEPTH(DEPTH), .PTR_W(PW), .SW_W(SW)) dut (
        .clk(clk), .rst(rst), .cfg(cfg_if.slave),
        .start(start), .ctx_len(ctx_len), .loop_en(loop_en), .stall(stall), .abort(abort),
        .switch(switch), .ctx_idx(ctx_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    pe_switch_ctx_seq #(.CTX_DEPTH(12), .PTR_W(PW), .SW_W(SW)) dut12 (
        .clk(clk), .rst(rst), .cfg(cfg12_if.slave),
        .start(start12), .ctx_len(len12), .loop_en(loop12), .stall(stall12), .abort(abort12),
        .switch(switch12), .ctx_idx(idx12), .busy(busy12), .done(done12), .cfg_err(err12)
    );

    always #5 clk = ~clk;

    // Reference model: a running sequence is a queue of context indices still to show.
    logic [SW-1:0] m_mem [DEPTH];
    int            m_seq[$];
    bit            m_run = 1'b0;
    bit            m_loop, m_err, m_done;
    int            m_n, m_head;
    exp_t          m_e;

    function automatic bit illegal_word(input logic [SW-1:0] w);
        for (int i = 0; i < SW/4; i++)
            if (int'(w[4*i +: 4]) > 8) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_run = 1'b0;
            m_err = 1'b0;
            m_seq.delete();
        end else if (!m_run) begin
            if (cfg_if.cfg_valid && !start) begin
                if (int'(cfg_if.cfg_addr) >= DEPTH) m_err = 1'b1;
                else begin
                    m_mem[cfg_if.cfg_addr] = cfg_if.cfg_data;
                    if (illegal_word(cfg_if.cfg_data)) m_err = 1'b1;
                end
            end
            if (start && ctx_len != 0) begin
                m_n = (int'(ctx_len) > DEPTH) ? DEPTH : int'(ctx_len);
                for (int i = 0; i < m_n; i++) m_seq.push_back(i);
                m_loop = loop_en;
                m_run  = 1'b1;
            end
        end else if (abort) begin
            m_run = 1'b0;
            m_seq.delete();
        end else if (!stall) begin
            m_head = m_seq.pop_front();
            if (m_loop) m_seq.push_back(m_head);
            if (m_seq.size() == 0) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end
        m_e.sw   = m_run ? m_mem[m_seq[0]] : {SW{1'b1}};
        m_e.idx  = m_run ? PW'(m_seq[0]) : '0;
        m_e.busy = m_run;
        m_e.done = m_done;
        m_e.err  = m_err;
        exp_q.push_back(m_e);
    end

    always @(negedge clk) begin
        exp_t   e, g;
        exp12_t e12, g12;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{sw: switch, idx: ctx_idx, busy: busy, done: done, err: cfg_err};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got sw=%h idx=%0d busy=%b done=%b err=%b expected sw=%h idx=%0d busy=%b done=%b err=%b",
                         $time, g.sw, g.idx, g.busy, g.done, g.err, e.sw, e.idx, e.busy, e.done, e.err);
            end
            vectors++;
            if (cfg_if.cfg_ready !== (!m_run && !start)) begin
                miscompares++;
                $display("FAIL cfg_ready t=%0t got %b expected %b", $time, cfg_if.cfg_ready, !m_run && !start);
            end
        end
        if (q12.size() > 0) begin
            e12 = q12.pop_front();
            g12 = '{sw: switch12, busy: busy12, done: done12, err: err12};
            vectors++;
            if (g12 !== e12) begin
                miscompares++;
                $display("FAIL depth12 t=%0t got sw=%h busy=%b done=%b err=%b expected sw=%h busy=%b done=%b err=%b",
                         $time, g12.sw, g12.busy, g12.done, g12.err, e12.sw, e12.busy, e12.done, e12.err);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [SW-1:0] good_word();
        logic [SW-1:0] w;
        for (int i = 0; i < SW/4; i++) w[4*i +: 4] = 4'($urandom_range(0, 8));
        return w;
    endfunction

    task automatic cfg_write(input int addr, input logic [SW-1:0] data);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = PW'(addr);
        cfg_if.cfg_data  = data;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic go(input int len, input bit lp);
        start   = 1'b1;
        ctx_len = (PW+1)'(len);
        loop_en = lp;
        tick();
        start = 1'b0;
    endtask

    task automatic tick12(input logic [SW-1:0] sw, input bit b, input bit d, input bit e);
        tick();
        q12.push_back('{sw: sw, busy: b, done: d, err: e});
    endtask

    initial begin
        logic [SW-1:0] w;
        rst = 1'b1; start = 1'b0; loop_en = 1'b0; stall = 1'b0; abort = 1'b0; ctx_len = '0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_data = '0;
        start12 = 1'b0; loop12 = 1'b0; stall12 = 1'b0; abort12 = 1'b0; len12 = '0;
        cfg12_if.cfg_valid = 1'b0; cfg12_if.cfg_addr = '0; cfg12_if.cfg_data = '0;
        tick(2);
        rst = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) cfg_write(i, good_word());
        cfg_write(0, 24'h012345);
        cfg_write(1, 24'h888888);
        cfg_write(2, 24'h876543);

        go(3, 1'b0);
        tick(5);

        // loop with a two-cycle stall on context 1, then abort
        go(3, 1'b1);
        tick();
        stall = 1'b1;
        tick(2);
        stall = 1'b0;
        tick(5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick(2);

        cfg_write(5, 24'h9FFFFF);
        go(6, 1'b0);
        tick(8);

        // write attempts while running must be ignored
        go(3, 1'b0);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = '0; cfg_if.cfg_data = 24'h111111;
        tick(2);
        cfg_if.cfg_valid = 1'b0;
        tick(2);
        go(3, 1'b0);
        tick(4);

        // start beats a simultaneous write
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = 4'd1; cfg_if.cfg_data = 24'h222222;
        go(2, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        tick(4);

        go(0, 1'b0);
        tick(2);

        go(20, 1'b0);
        tick(20);

        go(5, 1'b0);
        tick(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(2);

        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 7) == 0);
            ctx_len = (PW+1)'($urandom_range(0, 20));
            loop_en = ($urandom_range(0, 3) == 0);
            stall = ($urandom_range(0, 4) == 0);
            abort = ($urandom_range(0, 39) == 0);
            cfg_if.cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_if.cfg_addr  = PW'($urandom_range(0, DEPTH-1));
            w = good_word();
            if ($urandom_range(0, 9) == 0) w[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(9, 15));
            cfg_if.cfg_data = w;
            tick();
        end
        rst = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0; cfg_if.cfg_valid = 1'b0;
        tick(2);

        // 12-deep instance: address 13 lies outside the memory
        cfg12_if.cfg_valid = 1'b1;
        cfg12_if.cfg_addr = 4'd0; cfg12_if.cfg_data = 24'h123456;
        tick12(24'hFFFFFF, 1'b0, 1'b0, 1'b0);
        cfg12_if.cfg_addr = 4'd1; cfg12_if.cfg_data = 24'h654321;
        tick12(24'hFFFFFF, 1'b0, 1'b0, 1'b0);
        cfg12_if.cfg_addr = 4'd13; cfg12_if.cfg_data = 24'h777777;
        tick12(24'hFFFFFF, 1'b0, 1'b0, 1'b1);
        cfg12_if.cfg_valid = 1'b0;
        start12 = 1'b1; len12 = 5'd2;
        tick12(24'h123456, 1'b1, 1'b0, 1'b1);
        start12 = 1'b0;
        tick12(24'h654321, 1'b1, 1'b0, 1'b1);
        tick12(24'hFFFFFF, 1'b0, 1'b1, 1'b1);
        tick12(24'hFFFFFF, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick12(24'hFFFFFF, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick12(24'hFFFFFF, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
